date_set_ctrl: RTL and testbench

- User-facing set-date sequencer in front of the calendar datapath.
- Takes debounced single-cycle button pulses and walks an FSM through day, month and year edit fields.
- Holds a BCD edit buffer in the calendar's 19-bit date format, clamping it to a valid calendar date.
- Issues a one-cycle overwrite pulse so the calendar loads the buffer.

---
 rtl/date_set_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_date_set_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/date_set_ctrl.sv
// date_set_ctrl: set-date sequencer in front of the calendar datapath.
// Walks day -> month -> year edit fields from debounced one-cycle button
// pulses. It keeps a BCD edit buffer {day[5:0], month[4:0], year[7:0]} that
// always holds a valid calendar date, and issues a one-cycle overwrite pulse
// on commit.
//
// Optional build macro: DATE_SET_TIMEOUT_EN. When it is defined, an edit
// session that sees no button for TIMEOUT_CYCLES clocks aborts to IDLE.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | not editing; date_set holds its last value
// DAY    | editing the day field (field_sel = 01)
// MONTH  | editing the month field (field_sel = 10)
// YEAR   | editing the year field (field_sel = 11)
// COMMIT | single cycle with date_ow = 1; returns to IDLE
module date_set_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TO_W           = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [18:0] date_cur,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic        btn_dec,
  output logic [18:0] date_set,
  output logic        date_ow,
  output logic        busy,
  output logic [1:0]  field_sel
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DAY,
    S_MONTH,
    S_YEAR,
    S_COMMIT
  } state_t;

  localparam logic [18:0] RESET_DATE = {6'h01, 5'h01, 8'h00};

  // The timeout counter must be able to reach TIMEOUT_CYCLES-1.
  if (TIMEOUT_CYCLES < 2 || TO_W > 63 ||
      (64'd1 << TO_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_timeout_cfg
    $error("date_set_ctrl: TO_W too narrow for TIMEOUT_CYCLES");
  end

  // Years are 2000-2099, so the BCD year is a leap year exactly when it is
  // divisible by 4: even tens with units 0/4/8, odd tens with units 2/6.
  function automatic logic is_leap(input logic [7:0] yr);
    if (!yr[4]) return (yr[3:0] == 4'd0) || (yr[3:0] == 4'd4) || (yr[3:0] == 4'd8);
    else        return (yr[3:0] == 4'd2) || (yr[3:0] == 4'd6);
  endfunction

  function automatic logic [5:0] days_in_month(input logic [4:0] mon,
                                               input logic [7:0] yr);
    case (mon)
      5'h02:                      return is_leap(yr) ? 6'h29 : 6'h28;
      5'h04, 5'h06, 5'h09, 5'h11: return 6'h30;
      default:                    return 6'h31;
    endcase
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // BCD step that wraps hi->lo going up and lo->hi going down. Packed BCD
  // orders the same as the decimal value, so plain compares work.
  function automatic logic [7:0] wrap_step(input logic [7:0] v,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi,
                                           input logic       up);
    if (up) return (v >= hi) ? lo : bcd_inc(v);
    else    return (v <= lo) ? hi : bcd_dec(v);
  endfunction

  function automatic logic date_is_valid(input logic [18:0] d);
    logic [5:0] dd;
    logic [4:0] mm;
    logic [7:0] yy;
    dd = d[18:13];
    mm = d[12:8];
    yy = d[7:0];
    return (dd[3:0] <= 4'd9) && (mm[3:0] <= 4'd9) &&
           (yy[7:4] <= 4'd9) && (yy[3:0] <= 4'd9) &&
           (mm != 5'h00) && (mm <= 5'h12) &&
           (dd != 6'h00) && (dd <= days_in_month(mm, yy));
  endfunction

  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      S_DAY:   return 2'b01;
      S_MONTH: return 2'b10;
      S_YEAR:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [18:0] date_q, date_d;
  logic        ow_q;
  logic        busy_q;
  logic [1:0]  field_q;

  logic [5:0]  day_n;
  logic [4:0]  mon_n;
  logic [7:0]  yr_n;
  logic [5:0]  max_n;

`ifdef DATE_SET_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            any_btn;
`endif

  // Next-state, edit-buffer update and optional idle timeout.
  always_comb begin
    state_d = state_q;
    date_d  = date_q;
    day_n   = date_q[18:13];
    mon_n   = date_q[12:8];
    yr_n    = date_q[7:0];
    max_n   = 6'h00;

    case (state_q)
      S_IDLE: begin
        if (btn_mode) begin
          state_d = S_DAY;
          date_d  = date_is_valid(date_cur) ? date_cur : RESET_DATE;
        end
      end

      S_DAY, S_MONTH, S_YEAR: begin
        if (btn_mode) begin
          state_d = S_IDLE;
        end else if (btn_next) begin
          case (state_q)
            S_DAY:   state_d = S_MONTH;
            S_MONTH: state_d = S_YEAR;
            default: state_d = S_COMMIT;
          endcase
        end else if (btn_inc != btn_dec) begin
          case (state_q)
            S_DAY:   day_n = 6'(wrap_step({2'b00, day_n}, 8'h01,
                                          {2'b00, days_in_month(mon_n, yr_n)}, btn_inc));
            S_MONTH: mon_n = 5'(wrap_step({3'b000, mon_n}, 8'h01, 8'h12, btn_inc));
            default: yr_n  = wrap_step(yr_n, 8'h00, 8'h99, btn_inc);
          endcase
          // A month/year change can shrink the month; pull the day in.
          max_n = days_in_month(mon_n, yr_n);
          if (day_n > max_n) day_n = max_n;
          date_d = {day_n, mon_n, yr_n};
        end
      end

      S_COMMIT: state_d = S_IDLE;

      default:  state_d = S_IDLE;
    endcase

`ifdef DATE_SET_TIMEOUT_EN
    any_btn  = btn_mode | btn_next | btn_inc | btn_dec;
    to_cnt_d = '0;
    if (state_q == S_DAY || state_q == S_MONTH || state_q == S_YEAR) begin
      if (any_btn) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
        state_d  = S_IDLE;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif
  end

  // State and registered outputs; outputs are decoded from the next state so
  // they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      date_q   <= RESET_DATE;
      ow_q     <= 1'b0;
      busy_q   <= 1'b0;
      field_q  <= 2'b00;
`ifdef DATE_SET_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      date_q   <= date_d;
      ow_q     <= (state_d == S_COMMIT);
      busy_q   <= (state_d != S_IDLE);
      field_q  <= field_of(state_d);
`ifdef DATE_SET_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  assign date_set  = date_q;
  assign date_ow   = ow_q;
  assign busy      = busy_q;
  assign field_sel = field_q;

endmodule

// File: tb/tb_date_set_ctrl.sv
// Testbench for date_set_ctrl (default build). Directed steps from the test
// plan followed by random button/date traffic, all compared against an
// integer calendar model.
module tb_date_set_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] date_cur = '0;
  logic        btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [18:0] date_set;
  logic        date_ow, busy;
  logic [1:0]  field_sel;

  int checks = 0;
  int errors = 0;

  // Model: field 0 = idle, 1 day, 2 month, 3 year; commit is a separate flag.
  int m_field, m_d, m_m, m_y;
  bit m_commit;

  date_set_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .date_cur  (date_cur),
    .btn_mode  (btn_mode),
    .btn_next  (btn_next),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .date_set  (date_set),
    .date_ow   (date_ow),
    .busy      (busy),
    .field_sel (field_sel)
  );

  always #5 clk = ~clk;

  function automatic int dim(input int m, input int y);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic int wrap(input int v, input int lo, input int hi);
    if (v > hi) return lo;
    if (v < lo) return hi;
    return v;
  endfunction

  function automatic logic [18:0] pack(input int d, input int m, input int y);
    logic [5:0] bd;
    logic [4:0] bm;
    logic [7:0] by;
    bd = 6'(((d / 10) << 4) | (d % 10));
    bm = 5'(((m / 10) << 4) | (m % 10));
    by = 8'(((y / 10) << 4) | (y % 10));
    return {bd, bm, by};
  endfunction

  function automatic bit decode(input logic [18:0] c, output int d, output int m,
                                output int y);
    d = 0; m = 0; y = 0;
    if (c[16:13] > 9 || c[11:8] > 9 || c[7:4] > 9 || c[3:0] > 9) return 0;
    d = int'(c[18:17]) * 10 + int'(c[16:13]);
    m = int'(c[12]) * 10 + int'(c[11:8]);
    y = int'(c[7:4]) * 10 + int'(c[3:0]);
    if (m < 1 || m > 12) return 0;
    if (d < 1 || d > dim(m, y)) return 0;
    return 1;
  endfunction

  task automatic model_step(input bit rst, input bit mo, input bit nx,
                            input bit in, input bit de);
    int dd, mm, yy, step;
    if (rst) begin
      m_field = 0; m_commit = 0; m_d = 1; m_m = 1; m_y = 0;
      return;
    end
    if (m_commit) begin
      m_commit = 0;
      return;
    end
    if (m_field == 0) begin
      if (mo) begin
        if (decode(date_cur, dd, mm, yy)) begin
          m_d = dd; m_m = mm; m_y = yy;
        end else begin
          m_d = 1; m_m = 1; m_y = 0;
        end
        m_field = 1;
      end
      return;
    end
    if (mo) begin
      m_field = 0;
    end else if (nx) begin
      if (m_field == 3) begin
        m_field = 0; m_commit = 1;
      end else begin
        m_field = m_field + 1;
      end
    end else if (in != de) begin
      step = in ? 1 : -1;
      case (m_field)
        1:       m_d = wrap(m_d + step, 1, dim(m_m, m_y));
        2:       m_m = wrap(m_m + step, 1, 12);
        default: m_y = wrap(m_y + step, 0, 99);
      endcase
      if (m_d > dim(m_m, m_y)) m_d = dim(m_m, m_y);
    end
  endtask

  task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_model();
    chk("date_set", date_set, pack(m_d, m_m, m_y));
    chk("date_ow", 19'(date_ow), 19'(m_commit));
    chk("busy", 19'(busy), 19'((m_field != 0) || m_commit));
    chk("field_sel", 19'(field_sel), m_commit ? 19'd0 : 19'(m_field));
  endtask

  // One clock with the given buttons held across the edge, then compare.
  task automatic tick(input bit rst, input bit mo, input bit nx, input bit in,
                      input bit de);
    rst_n = ~rst; btn_mode = mo; btn_next = nx; btn_inc = in; btn_dec = de;
    @(posedge clk);
    model_step(rst, mo, nx, in, de);
    #1;
    rst_n = 1'b1; btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    chk_model();
  endtask

  task automatic press_mode(); tick(0, 1, 0, 0, 0); endtask
  task automatic press_next(); tick(0, 0, 1, 0, 0); endtask
  task automatic press_inc();  tick(0, 0, 0, 1, 0); endtask
  task automatic press_dec();  tick(0, 0, 0, 0, 1); endtask
  task automatic idle();       tick(0, 0, 0, 0, 0); endtask

  initial begin
    int r, d, m, y;
    logic [31:0] raw;
    logic [18:0] exp_rst;
    exp_rst = {6'h01, 5'h01, 8'h00};

    // Reset state
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("rst_date", date_set, exp_rst);
    chk("rst_busy", 19'(busy), 19'd0);

    // Enter and commit unchanged 15-06-24
    date_cur = {6'h15, 5'h06, 8'h24};
    press_mode();
    chk("enter_field", 19'(field_sel), 19'd1);
    chk("enter_date", date_set, {6'h15, 5'h06, 8'h24});
    press_next(); press_next(); press_next();
    chk("commit_ow", 19'(date_ow), 19'd1);
    chk("commit_date", date_set, {6'h15, 5'h06, 8'h24});
    chk("commit_busy", 19'(busy), 19'd1);
    idle();
    chk("post_commit_ow", 19'(date_ow), 19'd0);
    chk("post_commit_busy", 19'(busy), 19'd0);
    idle();

    // Day stepping in a 30-day month
    date_cur = {6'h09, 5'h04, 8'h23};
    press_mode();
    press_inc();
    chk("day_09_inc", 19'(date_set[18:13]), 19'(6'h10));
    for (int i = 0; i < 20; i++) press_inc();
    chk("day_at_30", 19'(date_set[18:13]), 19'(6'h30));
    press_inc();
    chk("day_wrap_up", 19'(date_set[18:13]), 19'(6'h01));
    press_dec();
    chk("day_wrap_dn", 19'(date_set[18:13]), 19'(6'h30));
    tick(0, 0, 0, 1, 1);
    chk("inc_dec_same", 19'(date_set[18:13]), 19'(6'h30));
    press_mode();

    // Month change clamps the day
    date_cur = {6'h31, 5'h01, 8'h24};
    press_mode(); press_next(); press_inc();
    chk("clamp_leap", date_set, {6'h29, 5'h02, 8'h24});
    press_mode();
    date_cur = {6'h31, 5'h01, 8'h23};
    press_mode(); press_next(); press_inc();
    chk("clamp_noleap", date_set, {6'h28, 5'h02, 8'h23});
    press_mode();
    date_cur = {6'h31, 5'h03, 8'h23};
    press_mode(); press_next(); press_inc();
    chk("clamp_apr", date_set, {6'h30, 5'h04, 8'h23});
    press_dec(); press_dec(); press_dec(); press_dec();
    chk("month_wrap_dn", 19'(date_set[12:8]), 19'(5'h12));
    press_inc();
    chk("month_wrap_up", 19'(date_set[12:8]), 19'(5'h01));
    press_mode();

    // Year wrap and leap-day clamp
    date_cur = {6'h15, 5'h06, 8'h99};
    press_mode(); press_next(); press_next(); press_inc();
    chk("year_wrap_up", 19'(date_set[7:0]), 19'(8'h00));
    press_dec();
    chk("year_wrap_dn", 19'(date_set[7:0]), 19'(8'h99));
    press_mode();
    date_cur = {6'h29, 5'h02, 8'h24};
    press_mode(); press_next(); press_next(); press_inc();
    chk("year_clamp", date_set, {6'h28, 5'h02, 8'h25});

    // Abort from MONTH, invalid entry date
    press_mode();
    press_mode(); press_next();
    press_mode();
    chk("abort_ow", 19'(date_ow), 19'd0);
    chk("abort_busy", 19'(busy), 19'd0);
    date_cur = {6'h3F, 5'h13, 8'hA0};
    press_mode();
    chk("invalid_entry", date_set, exp_rst);

    // No timeout in the default build
    for (int i = 0; i < 40; i++) idle();
    chk("no_timeout", 19'(busy), 19'd1);

    // Reset during COMMIT drops the pulse
    press_next(); press_next(); press_next();
    chk("pre_rst_ow", 19'(date_ow), 19'd1);
    tick(1, 0, 0, 0, 0);
    chk("rst_commit_ow", 19'(date_ow), 19'd0);
    chk("rst_commit_date", date_set, exp_rst);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 1) == 1) begin
        m = int'($urandom_range(1, 12));
        y = int'($urandom_range(0, 99));
        d = int'($urandom_range(1, dim(m, y)));
        date_cur = pack(d, m, y);
      end else begin
        raw = $urandom();
        date_cur = raw[18:0];
      end
      if      (r < 2)  tick(1, 0, 0, 0, 0);
      else if (r < 28) idle();
      else if (r < 34) press_mode();
      else if (r < 48) press_next();
      else if (r < 72) press_inc();
      else if (r < 94) press_dec();
      else             tick(0, 0, 0, 1, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
